// File: rtl/clk_lock_supervisor_pkg.sv
// Shared types and constants for the clock-lock supervisor.
// Optional lock-loss counting is enabled by defining CLK_LOCK_LOSS_CNT_EN.
package clk_sup_pkg;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } chanState_e;

    localparam int DefNClk           = 2;
    localparam int DefRstPulseCyc    = 8;
    localparam int DefLockTimeoutCyc = 65536;
    localparam int DefLockStableCyc  = 1024;
    localparam int DefMaxRetries     = 3;

    // One counter serves every phase, so it is sized for the longest one.
    function automatic int cntWidth(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/clk_lock_supervisor_chan.sv
// One supervised clock-generator channel: LOCKED synchroniser, sequencing FSM and counters.
// Defining CLK_LOCK_LOSS_CNT_EN adds a saturating count of lock losses seen in RUN.
module clk_lock_supervisor_chan
    import clk_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DefRstPulseCyc,
    parameter int LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
    parameter int LOCK_STABLE_CYC  = DefLockStableCyc,
    parameter int MAX_RETRIES      = DefMaxRetries
) (
    input  logic       clk_i,
    input  logic       rstN_i,
    input  logic       lockedRaw_i,
    input  logic       softRst_i,
    output logic       mmcmRst_o,
    output logic       locked_o,
    output logic       fail_o
`ifdef CLK_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] lossCnt_o
`endif
);

    localparam int CntW   = cntWidth(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int RetryW = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [CntW-1:0]   RstLast     = CntW'(RST_PULSE_CYC - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYC - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

    logic              syncMeta_q;
    logic              syncLock_q;
    chanState_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic [RetryW-1:0] retryCnt_q;
    logic              mmcmRst_q;
    logic              locked_q;
    logic              fail_q;

    // LOCKED is asynchronous to clk; only syncLock_q is used by the FSM.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            syncMeta_q <= 1'b0;
            syncLock_q <= 1'b0;
        end else begin
            syncMeta_q <= lockedRaw_i;
            syncLock_q <= syncMeta_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            state_q    <= RESET;
            cnt_q      <= '0;
            retryCnt_q <= '0;
            mmcmRst_q  <= 1'b1;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else if (softRst_i) begin
            state_q    <= RESET;
            cnt_q      <= '0;
            retryCnt_q <= '0;
            mmcmRst_q  <= 1'b1;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    if (cnt_q == RstLast) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        mmcmRst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                // A lock seen on the timeout cycle still wins over the retry.
                WAIT_LOCK: begin
                    if (syncLock_q) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_q     <= '0;
                        mmcmRst_q <= 1'b1;
                        if (retryCnt_q < RetryMax) begin
                            retryCnt_q <= retryCnt_q + RetryW'(1);
                            state_q    <= RESET;
                        end else begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                STABLE: begin
                    if (!syncLock_q) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == StableLast) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        retryCnt_q <= '0;
                        locked_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RUN: begin
                    if (!syncLock_q) begin
                        state_q   <= RESET;
                        cnt_q     <= '0;
                        mmcmRst_q <= 1'b1;
                        locked_q  <= 1'b0;
                    end
                end
                FAIL: begin
                    state_q <= FAIL;
                end
                default: begin
                    state_q   <= RESET;
                    cnt_q     <= '0;
                    mmcmRst_q <= 1'b1;
                    locked_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_LOCK_LOSS_CNT_EN
    logic [7:0] lossCnt_q;

    // A soft restart in the same cycle is not a lock loss.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            lossCnt_q <= '0;
        end else if (!softRst_i && state_q == RUN && !syncLock_q && lossCnt_q != 8'hFF) begin
            lossCnt_q <= lossCnt_q + 8'd1;
        end
    end

    assign lossCnt_o = lossCnt_q;
`endif

    assign mmcmRst_o = mmcmRst_q;
    assign locked_o  = locked_q;
    assign fail_o    = fail_q;

endmodule

// File: rtl/clk_lock_supervisor.sv
// Supervises N_CLK clock generators: reset pulsing, lock timeout/retry, lock qualification.
// Defining CLK_LOCK_LOSS_CNT_EN adds the packed lock_loss_cnt output (8 bits per channel).
module clk_lock_supervisor
    import clk_sup_pkg::*;
#(
    parameter int N_CLK            = DefNClk,
    parameter int RST_PULSE_CYC    = DefRstPulseCyc,
    parameter int LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
    parameter int LOCK_STABLE_CYC  = DefLockStableCyc,
    parameter int MAX_RETRIES      = DefMaxRetries
) (
    input  logic               clk,
    input  logic               glbl_rst_n,
    input  logic [N_CLK-1:0]   locked_in,
    input  logic [N_CLK-1:0]   soft_rst,
    output logic [N_CLK-1:0]   mmcm_rst,
    output logic [N_CLK-1:0]   locked,
    output logic [N_CLK-1:0]   fail,
    output logic               all_locked
`ifdef CLK_LOCK_LOSS_CNT_EN
    ,
    output logic [N_CLK*8-1:0] lock_loss_cnt
`endif
);

    logic allLocked_d;
    logic allLocked_q;

    for (genvar g = 0; g < N_CLK; g++) begin : gChan
        clk_lock_supervisor_chan #(
            .RST_PULSE_CYC   (RST_PULSE_CYC),
            .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
            .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
            .MAX_RETRIES     (MAX_RETRIES)
        ) uChan (
            .clk_i      (clk),
            .rstN_i     (glbl_rst_n),
            .lockedRaw_i(locked_in[g]),
            .softRst_i  (soft_rst[g]),
            .mmcmRst_o  (mmcm_rst[g]),
            .locked_o   (locked[g]),
            .fail_o     (fail[g])
`ifdef CLK_LOCK_LOSS_CNT_EN
            ,
            .lossCnt_o  (lock_loss_cnt[8*g +: 8])
`endif
        );
    end

    assign allLocked_d = &locked;

    always_ff @(posedge clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            allLocked_q <= 1'b0;
        end else begin
            allLocked_q <= allLocked_d;
        end
    end

    assign all_locked = allLocked_q;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Self-checking bench for clk_lock_supervisor: directed vector table, async reset sequence,
// then random LOCKED/soft-reset traffic against a timestamp-based reference model.
module tb_clk_lock_supervisor;

    localparam int N_CLK       = 2;
    localparam int RST_PULSE   = 8;
    localparam int TIMEOUT     = 64;
    localparam int STABLE_CYC  = 16;
    localparam int MAX_RETRIES = 3;

    logic       clk;
    logic       glblRstN;
    logic [1:0] lockedIn;
    logic [1:0] softRst;
    logic [1:0] mmcmRst;
    logic [1:0] locked;
    logic [1:0] fail;
    logic       allLocked;
`ifdef CLK_LOCK_LOSS_CNT_EN
    logic [15:0] lockLossCnt;
`endif

    clk_lock_supervisor #(
        .N_CLK           (N_CLK),
        .RST_PULSE_CYC   (RST_PULSE),
        .LOCK_TIMEOUT_CYC(TIMEOUT),
        .LOCK_STABLE_CYC (STABLE_CYC),
        .MAX_RETRIES     (MAX_RETRIES)
    ) dut (
        .clk          (clk),
        .glbl_rst_n   (glblRstN),
        .locked_in    (lockedIn),
        .soft_rst     (softRst),
        .mmcm_rst     (mmcmRst),
        .locked       (locked),
        .fail         (fail),
        .all_locked   (allLocked)
`ifdef CLK_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lockLossCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model phases are timestamped: each channel remembers the edge at which it entered its phase.
    typedef enum int {M_PULSE, M_WAIT, M_QUAL, M_UP, M_DEAD} mPhase_e;

    mPhase_e    mPhase[N_CLK];
    int         mEnter[N_CLK];
    int         mTries[N_CLK];
    int         mLoss[N_CLK];
    logic       mPipe1[N_CLK];
    logic       mPipe2[N_CLK];
    logic [1:0] expMmcm;
    logic [1:0] expLocked;
    logic [1:0] expFail;
    logic       expAll;
    int         edgeCnt;
    int         nChecks;
    int         nFails;

    typedef struct {
        int         edgeNo;
        logic [1:0] lockIn;
        logic [1:0] softIn;
        logic [1:0] expMmcm;
        logic [1:0] expLocked;
        logic [1:0] expFail;
        logic       expAll;
        string      name;
    } vecRow_t;

    vecRow_t rows[$];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    function automatic void refreshExp();
        for (int ch = 0; ch < N_CLK; ch++) begin
            expMmcm[ch]   = (mPhase[ch] == M_PULSE) || (mPhase[ch] == M_DEAD);
            expLocked[ch] = (mPhase[ch] == M_UP);
            expFail[ch]   = (mPhase[ch] == M_DEAD);
        end
    endfunction

    function automatic void modelReset();
        edgeCnt = 0;
        for (int ch = 0; ch < N_CLK; ch++) begin
            mPhase[ch] = M_PULSE;
            mEnter[ch] = 0;
            mTries[ch] = 0;
            mLoss[ch]  = 0;
            mPipe1[ch] = 1'b0;
            mPipe2[ch] = 1'b0;
        end
        expAll = 1'b0;
        refreshExp();
    endfunction

    function automatic void modelStep(input logic [1:0] lin, input logic [1:0] srst);
        logic prevAnd;
        logic seen;
        int   age;
        prevAnd = &expLocked;
        edgeCnt++;
        for (int ch = 0; ch < N_CLK; ch++) begin
            seen       = mPipe2[ch];
            mPipe2[ch] = mPipe1[ch];
            mPipe1[ch] = lin[ch];
            age        = edgeCnt - mEnter[ch];
            if (srst[ch]) begin
                mPhase[ch] = M_PULSE;
                mEnter[ch] = edgeCnt;
                mTries[ch] = 0;
            end else begin
                case (mPhase[ch])
                    M_PULSE: begin
                        if (age == RST_PULSE) begin
                            mPhase[ch] = M_WAIT;
                            mEnter[ch] = edgeCnt;
                        end
                    end
                    M_WAIT: begin
                        if (seen) begin
                            mPhase[ch] = M_QUAL;
                            mEnter[ch] = edgeCnt;
                        end else if (age == TIMEOUT) begin
                            mEnter[ch] = edgeCnt;
                            if (mTries[ch] < MAX_RETRIES) begin
                                mTries[ch]++;
                                mPhase[ch] = M_PULSE;
                            end else begin
                                mPhase[ch] = M_DEAD;
                            end
                        end
                    end
                    M_QUAL: begin
                        if (!seen) begin
                            mPhase[ch] = M_WAIT;
                            mEnter[ch] = edgeCnt;
                        end else if (age == STABLE_CYC) begin
                            mPhase[ch] = M_UP;
                            mEnter[ch] = edgeCnt;
                            mTries[ch] = 0;
                        end
                    end
                    M_UP: begin
                        if (!seen) begin
                            mPhase[ch] = M_PULSE;
                            mEnter[ch] = edgeCnt;
                            if (mLoss[ch] < 255) mLoss[ch]++;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
        expAll = prevAnd;
        refreshExp();
    endfunction

    task automatic checkOutput();
        compare("model/mmcm_rst", 32'(mmcmRst), 32'(expMmcm));
        compare("model/locked", 32'(locked), 32'(expLocked));
        compare("model/fail", 32'(fail), 32'(expFail));
        compare("model/all_locked", 32'(allLocked), 32'(expAll));
`ifdef CLK_LOCK_LOSS_CNT_EN
        compare("model/lock_loss_cnt", 32'(lockLossCnt), {16'd0, mLoss[1][7:0], mLoss[0][7:0]});
`endif
    endtask

    task automatic applyStimulus(input logic [1:0] lin, input logic [1:0] srst);
        lockedIn = lin;
        softRst  = srst;
        @(posedge clk);
        modelStep(lin, srst);
        #1;
        checkOutput();
    endtask

    task automatic checkRow(input vecRow_t r);
        compare({r.name, "/mmcm_rst"}, 32'(mmcmRst), 32'(r.expMmcm));
        compare({r.name, "/locked"}, 32'(locked), 32'(r.expLocked));
        compare({r.name, "/fail"}, 32'(fail), 32'(r.expFail));
        compare({r.name, "/all_locked"}, 32'(allLocked), 32'(r.expAll));
    endtask

    task automatic checkResetValues(input string tag);
        compare({tag, "/mmcm_rst"}, 32'(mmcmRst), 32'h3);
        compare({tag, "/locked"}, 32'(locked), 32'h0);
        compare({tag, "/fail"}, 32'(fail), 32'h0);
        compare({tag, "/all_locked"}, 32'(allLocked), 32'h0);
`ifdef CLK_LOCK_LOSS_CNT_EN
        compare({tag, "/lock_loss_cnt"}, 32'(lockLossCnt), 32'h0);
`endif
    endtask

    initial begin
        logic [1:0] lin;
        logic [1:0] srst;
        logic [1:0] dead;

        nChecks  = 0;
        nFails   = 0;
        glblRstN = 1'b0;
        lockedIn = 2'b00;
        softRst  = 2'b00;

        // Edge n is the n-th rising edge after release; inputs of a row apply from the previous row's edge.
        rows.push_back(vecRow_t'{7,   2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, "pulseHigh"});
        rows.push_back(vecRow_t'{8,   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "pulseRelease"});
        rows.push_back(vecRow_t'{20,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "waitLock"});
        rows.push_back(vecRow_t'{38,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "stableNotYet"});
        rows.push_back(vecRow_t'{39,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "lockedRise"});
        rows.push_back(vecRow_t'{71,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "ch1FirstWait"});
        rows.push_back(vecRow_t'{72,  2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, "ch1Retry1"});
        rows.push_back(vecRow_t'{79,  2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, "ch1Retry1End"});
        rows.push_back(vecRow_t'{80,  2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "ch1Retry1Rel"});
        rows.push_back(vecRow_t'{100, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "ch0Run"});
        rows.push_back(vecRow_t'{102, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "lossNotYet"});
        rows.push_back(vecRow_t'{103, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, "lossDetected"});
        rows.push_back(vecRow_t'{110, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, "lossPulseEnd"});
        rows.push_back(vecRow_t'{111, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "lossPulseRel"});
        rows.push_back(vecRow_t'{115, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "stableBeforeGlitch"});
        rows.push_back(vecRow_t'{116, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "glitchCycle"});
        rows.push_back(vecRow_t'{134, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "glitchDelayed"});
        rows.push_back(vecRow_t'{135, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "glitchRelock"});
        rows.push_back(vecRow_t'{143, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "ch1Wait2"});
        rows.push_back(vecRow_t'{144, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, "ch1Retry2"});
        rows.push_back(vecRow_t'{152, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "ch1Retry2Rel"});
        rows.push_back(vecRow_t'{216, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, "ch1Retry3"});
        rows.push_back(vecRow_t'{287, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "ch1LastWait"});
        rows.push_back(vecRow_t'{288, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, "ch1Fail"});
        rows.push_back(vecRow_t'{300, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, "ch1FailHeld"});
        rows.push_back(vecRow_t'{301, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, "softRstClear"});
        rows.push_back(vecRow_t'{308, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, "softPulseEnd"});
        rows.push_back(vecRow_t'{309, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "softPulseRel"});
        rows.push_back(vecRow_t'{327, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, "ch1StableNotYet"});
        rows.push_back(vecRow_t'{328, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, "ch1Locked"});
        rows.push_back(vecRow_t'{329, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, "allLocked"});
        rows.push_back(vecRow_t'{332, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 1'b1, "ch0LossAllLag"});
        rows.push_back(vecRow_t'{333, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, "allLockedDrop"});

        #12;
        checkResetValues("initReset");
        @(negedge clk);
        glblRstN = 1'b1;
        modelReset();

        $display("[TB] directed vector table, %0d rows", rows.size());
        for (int r = 0; r < rows.size(); r++) begin
            while (edgeCnt < rows[r].edgeNo) applyStimulus(rows[r].lockIn, rows[r].softIn);
            checkRow(rows[r]);
        end
`ifdef CLK_LOCK_LOSS_CNT_EN
        compare("lossCountCh0", 32'(lockLossCnt[7:0]), 32'd2);
`endif

        // Channel 0 re-enters STABLE at edge 341; pull the global reset mid-qualification.
        while (edgeCnt < 345) applyStimulus(2'b11, 2'b00);
        #2;
        glblRstN = 1'b0;
        #1;
        checkResetValues("asyncReset");
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("holdReset");
        @(negedge clk);
        glblRstN = 1'b1;
        modelReset();
        while (edgeCnt < 7) applyStimulus(2'b11, 2'b00);
        compare("restartPulseHigh", 32'(mmcmRst), 32'h3);
        applyStimulus(2'b11, 2'b00);
        compare("restartPulseRel", 32'(mmcmRst), 32'h0);

        $display("[TB] random traffic against reference model");
        lin = 2'b11;
        for (int seg = 0; seg < 8; seg++) begin
            for (int ch = 0; ch < N_CLK; ch++) dead[ch] = ($urandom_range(3) == 0);
            for (int cyc = 0; cyc < 400; cyc++) begin
                for (int ch = 0; ch < N_CLK; ch++) begin
                    if (dead[ch]) lin[ch] = 1'b0;
                    else if ($urandom_range(59) == 0) lin[ch] = ~lin[ch];
                    srst[ch] = ($urandom_range(149) == 0);
                end
                applyStimulus(lin, srst);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
